// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage LoongArch32 pipeline.
//
// The stage sits between exe_stage and wb_stage. It registers the EX result
// bus and, on loads, waits for the data-SRAM read response. It then extracts
// and extends byte, halfword or word data and passes the writeback value to WB.
// It also reports its dest, result and load-stall state back to ID, which
// uses them for bypassing and for the load-use interlock.
//
// Ports
//   clk                  clock; all state updates on the rising edge
//   reset                synchronous, active-high reset
//   ws_allowin           WB can accept an instruction this cycle
//   ms_allowin           MEM can accept an instruction this cycle
//   es_to_ms_valid       EX presents a valid instruction
//   es_to_ms_bus         {res_from_mem, gr_we, dest[4:0], ld_type[2:0],
//                         alu_result[31:0], pc[31:0]}
//   ms_to_ws_valid       MEM presents a valid instruction to WB
//   ms_to_ws_bus         {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
//   ms_to_ds_dest        dest while a writing instruction is held, else 0
//   ms_to_ds_result      final_result, for bypass
//   ms_to_ds_load_stall  a held load is still waiting for its data
//   data_sram_rdata      read data, valid while data_sram_data_ok is high
//   data_sram_data_ok    one-cycle read-response pulse
//
// Handshake: a transfer happens on a rising edge where the producer's valid
// and the consumer's allowin are both high. Valid never depends on allowin of
// the same interface. The stage state is visible as state_q (ms_state_t) for
// checkers to bind to.

module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 74,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [4:0]                 ms_to_ds_dest,
    output logic [31:0]                ms_to_ds_result,
    output logic                       ms_to_ds_load_stall,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       data_sram_data_ok
);

    // MS_EMPTY : no instruction held (ms_valid = 0)
    // MS_PASS  : non-load held; it can leave as soon as WB accepts it
    // MS_WAIT  : load held, read response not yet seen
    // MS_BUF   : load held, response captured in rdata_buf (rdata_buf_valid)
    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_PASS  = 2'd1,
        MS_WAIT  = 2'd2,
        MS_BUF   = 2'd3
    } ms_state_t;

    ms_state_t state_q;
    ms_state_t state_d;

    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q;
    logic [31:0]                rdata_buf;

    // Fields of the registered EX bus
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [2:0]  ld_type;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign res_from_mem = es_bus_q[73];
    assign gr_we        = es_bus_q[72];
    assign dest         = es_bus_q[71:67];
    assign ld_type      = es_bus_q[66:64];
    assign alu_result   = es_bus_q[63:32];
    assign pc           = es_bus_q[31:0];

    // Stage control signals
    logic        ms_valid;
    logic        rdata_buf_valid;
    logic        data_avail;
    logic        ms_ready_go;
    logic        ms_leave;
    logic [31:0] load_data;
    logic [31:0] load_ext;
    logic [31:0] final_result;

    // ------------------------------------------------------------------
    // State register (plus the data it qualifies)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MS_EMPTY;
            es_bus_q  <= '0;
            rdata_buf <= '0;
        end else begin
            state_q <= state_d;
            if (es_to_ms_valid && ms_allowin) begin
                es_bus_q <= es_to_ms_bus;
            end
            // Response arrived but WB did not take the load: keep the data,
            // because the SRAM drives it for this single cycle only.
            if (state_q == MS_WAIT && data_sram_data_ok && !ms_leave) begin
                rdata_buf <= data_sram_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (ms_allowin) begin
            // Covers empty, plain leave, and leave-with-capture: a newly
            // captured load always starts waiting, so a response buffered
            // for the previous load never carries over.
            if (es_to_ms_valid) begin
                state_d = es_to_ms_bus[73] ? MS_WAIT : MS_PASS;
            end else begin
                state_d = MS_EMPTY;
            end
        end else if (state_q == MS_WAIT && data_sram_data_ok) begin
            state_d = MS_BUF;
        end
        // In MS_BUF a further data_ok is ignored: the buffer has priority.
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        ms_valid        = (state_q != MS_EMPTY);
        rdata_buf_valid = (state_q == MS_BUF);
        data_avail      = rdata_buf_valid | data_sram_data_ok;
        ms_ready_go     = !res_from_mem | data_avail;
        ms_allowin      = !ms_valid | (ms_ready_go & ws_allowin);
        ms_to_ws_valid  = ms_valid & ms_ready_go;
        ms_leave        = ms_to_ws_valid & ws_allowin;

        load_data = rdata_buf_valid ? rdata_buf : data_sram_rdata;

        // Byte/half select uses the low address bits; a misaligned half just
        // ignores bit 0, alignment faults are raised elsewhere.
        load_ext = load_data;
        case (ld_type[1:0])
            2'b01: begin
                logic [7:0] b;
                case (alu_result[1:0])
                    2'd0:    b = load_data[7:0];
                    2'd1:    b = load_data[15:8];
                    2'd2:    b = load_data[23:16];
                    default: b = load_data[31:24];
                endcase
                load_ext = {{24{b[7] & ~ld_type[2]}}, b};
            end
            2'b10: begin
                logic [15:0] h;
                h = alu_result[1] ? load_data[31:16] : load_data[15:0];
                load_ext = {{16{h[15] & ~ld_type[2]}}, h};
            end
            default: load_ext = load_data;
        endcase

        final_result = res_from_mem ? load_ext : alu_result;

        ms_to_ws_bus        = {gr_we, dest, final_result, pc};
        ms_to_ds_dest       = {5{ms_valid & gr_we}} & dest;
        ms_to_ds_result     = final_result;
        ms_to_ds_load_stall = ms_valid & res_from_mem & !data_avail;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. Expected WB transfers are queued
// as instructions are issued; a monitor pops one per accepted transfer.

module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [4:0]  ms_to_ds_dest;
    logic [31:0] ms_to_ds_result;
    logic        ms_to_ds_load_stall;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;

    logic [69:0] exp_q[$];
    int n_cmp;
    int n_err;

    mem_stage #(
        .ES_TO_MS_BUS_WD(74),
        .MS_TO_WS_BUS_WD(70)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ws_allowin          (ws_allowin),
        .ms_allowin          (ms_allowin),
        .es_to_ms_valid      (es_to_ms_valid),
        .es_to_ms_bus        (es_to_ms_bus),
        .ms_to_ws_valid      (ms_to_ws_valid),
        .ms_to_ws_bus        (ms_to_ws_bus),
        .ms_to_ds_dest       (ms_to_ds_dest),
        .ms_to_ds_result     (ms_to_ds_result),
        .ms_to_ds_load_stall (ms_to_ds_load_stall),
        .data_sram_rdata     (data_sram_rdata),
        .data_sram_data_ok   (data_sram_data_ok)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_es(input logic res, input logic we, input logic [4:0] d,
                            input logic [2:0] ld, input logic [31:0] alu,
                            input logic [31:0] pc);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {res, we, d, ld, alu, pc};
    endtask

    task automatic push_exp(input logic we, input logic [4:0] d,
                            input logic [31:0] res, input logic [31:0] pc);
        exp_q.push_back({we, d, res, pc});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Load whose response arrives in its first MEM cycle with WB ready.
    task automatic fast_load(input logic [2:0] ld, input logic [1:0] a,
                             input logic [31:0] rd, input logic [31:0] exp,
                             input logic [31:0] pc);
        drive_es(1'b1, 1'b1, 5'd3, ld, {30'h0000_0400, a}, pc);
        push_exp(1'b1, 5'd3, exp, pc);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        @(negedge clk);
        chk("fast_stall", {31'd0, ms_to_ds_load_stall}, 32'd0);
        chk("fast_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got %h expected no transfer", ms_to_ws_bus);
            end else begin
                logic [69:0] e;
                e = exp_q.pop_front();
                if (ms_to_ws_bus !== e) begin
                    n_err++;
                    $display("FAIL wb_bus: got %h expected %h", ms_to_ws_bus, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        reset             = 1'b1;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_rdata   = 32'h0;
        data_sram_data_ok = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_allowin", {31'd0, ms_allowin}, 32'd1);
        chk("rst_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("rst_dest", {27'd0, ms_to_ds_dest}, 32'd0);
        chk("rst_stall", {31'd0, ms_to_ds_load_stall}, 32'd0);
        step();

        // Non-load pass-through
        drive_es(1'b0, 1'b1, 5'd5, 3'b000, 32'h1234_5678, 32'h1c00_0000);
        push_exp(1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000);
        step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("nl_dest", {27'd0, ms_to_ds_dest}, 32'd5);
        chk("nl_stall", {31'd0, ms_to_ds_load_stall}, 32'd0);
        chk("nl_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        chk("nl_result", ms_to_ds_result, 32'h1234_5678);
        step();

        // Non-writing instruction reports no dest
        drive_es(1'b0, 1'b0, 5'd7, 3'b000, 32'h0000_00aa, 32'h1c00_0004);
        push_exp(1'b0, 5'd7, 32'h0000_00aa, 32'h1c00_0004);
        step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("nowe_dest", {27'd0, ms_to_ds_dest}, 32'd0);
        step();

        // Byte loads
        fast_load(3'b001, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80, 32'h1c00_0010);
        fast_load(3'b101, 2'd3, 32'h80FF_7F01, 32'h0000_0080, 32'h1c00_0014);
        fast_load(3'b001, 2'd1, 32'h80FF_7F01, 32'h0000_007F, 32'h1c00_0018);
        fast_load(3'b001, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF, 32'h1c00_001c);
        fast_load(3'b101, 2'd0, 32'h80FF_7F01, 32'h0000_0001, 32'h1c00_0020);
        // Halfword loads (a[0] ignored)
        fast_load(3'b010, 2'd0, 32'h8001_ABCD, 32'hFFFF_ABCD, 32'h1c00_0024);
        fast_load(3'b110, 2'd2, 32'h8001_ABCD, 32'h0000_8001, 32'h1c00_0028);
        fast_load(3'b010, 2'd2, 32'h8001_ABCD, 32'hFFFF_8001, 32'h1c00_002c);
        fast_load(3'b010, 2'd3, 32'h8001_ABCD, 32'hFFFF_8001, 32'h1c00_0030);
        fast_load(3'b110, 2'd1, 32'h8001_ABCD, 32'h0000_ABCD, 32'h1c00_0034);
        // Word loads (ld_type[2] and address ignored)
        fast_load(3'b011, 2'd0, 32'h8001_ABCD, 32'h8001_ABCD, 32'h1c00_0038);
        fast_load(3'b100, 2'd2, 32'h8001_ABCD, 32'h8001_ABCD, 32'h1c00_003c);

        // Delayed response
        drive_es(1'b1, 1'b1, 5'd9, 3'b000, 32'h0000_2000, 32'h1c00_0040);
        push_exp(1'b1, 5'd9, 32'hDEAD_BEEF, 32'h1c00_0040);
        step();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dly_stall", {31'd0, ms_to_ds_load_stall}, 32'd1);
            chk("dly_valid", {31'd0, ms_to_ws_valid}, 32'd0);
            chk("dly_allowin", {31'd0, ms_allowin}, 32'd0);
            chk("dly_dest", {27'd0, ms_to_ds_dest}, 32'd9);
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("dly_done_stall", {31'd0, ms_to_ds_load_stall}, 32'd0);
        chk("dly_done_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;

        // WB backpressure: response buffered, stray data_ok ignored, then
        // leave and capture of the next load in the same cycle.
        drive_es(1'b1, 1'b1, 5'd4, 3'b000, 32'h0000_3000, 32'h1c00_0050);
        push_exp(1'b1, 5'd4, 32'hCAFE_F00D, 32'h1c00_0050);
        step();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        chk("bp_stall0", {31'd0, ms_to_ds_load_stall}, 32'd0);
        chk("bp_valid0", {31'd0, ms_to_ws_valid}, 32'd1);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        @(negedge clk);
        chk("bp_stall1", {31'd0, ms_to_ds_load_stall}, 32'd0);
        chk("bp_result1", ms_to_ds_result, 32'hCAFE_F00D);
        chk("bp_allowin1", {31'd0, ms_allowin}, 32'd0);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        @(negedge clk);
        chk("bp_stray_result", ms_to_ds_result, 32'hCAFE_F00D);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        ws_allowin        = 1'b1;
        drive_es(1'b1, 1'b1, 5'd6, 3'b101, 32'h0000_4000, 32'h1c00_0054);
        push_exp(1'b1, 5'd6, 32'h0000_005A, 32'h1c00_0054);
        @(negedge clk);
        chk("bp_leave_allowin", {31'd0, ms_allowin}, 32'd1);
        step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("swap_stall", {31'd0, ms_to_ds_load_stall}, 32'd1);
        chk("swap_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5A5A_5A5A;
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;

        // Reset during WAIT_DATA, then a stray response
        drive_es(1'b1, 1'b1, 5'd8, 3'b000, 32'h0000_5000, 32'h1c00_0060);
        step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("rl_stall_before", {31'd0, ms_to_ds_load_stall}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rl_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("rl_dest", {27'd0, ms_to_ds_dest}, 32'd0);
        chk("rl_stall", {31'd0, ms_to_ds_load_stall}, 32'd0);
        chk("rl_allowin", {31'd0, ms_allowin}, 32'd1);
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1212_1212;
        @(negedge clk);
        chk("stray_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("stray_stall", {31'd0, ms_to_ds_load_stall}, 32'd0);
        chk("stray_dest", {27'd0, ms_to_ds_dest}, 32'd0);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        @(negedge clk);
        chk("stray_after_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        step();

        // Back-to-back non-loads, one per cycle
        for (int i = 0; i < 4; i++) begin
            drive_es(1'b0, 1'b1, 5'(10 + i), 3'b000, 32'hA000_0000 + 32'(i),
                     32'h1c00_0100 + 32'(4 * i));
            push_exp(1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i),
                     32'h1c00_0100 + 32'(4 * i));
            if (i > 0) begin
                @(negedge clk);
                chk("b2b_allowin", {31'd0, ms_allowin}, 32'd1);
            end
            step();
        end
        es_to_ms_valid = 1'b0;
        repeat (3) step();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the 5-stage LoongArch32 pipeline, between exe_stage and wb_stage.
- Takes the EX result bus and waits for the data-SRAM read response on loads.
- Extracts and extends byte/halfword/word load data and presents the final writeback value to WB.
- Provides MEM-stage dest/result/stall information to ID for bypass and load-use interlock.

Parameters:
ES_TO_MS_BUS_WD, 74, width of EX->MEM bus
MS_TO_WS_BUS_WD, 70, width of MEM->WB bus

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ws_allowin  input  1  WB can accept an instruction this cycle
ms_allowin  output  1  MEM can accept an instruction this cycle
es_to_ms_valid  input  1  EX presents a valid instruction
es_to_ms_bus  input  74  [73] res_from_mem, [72] gr_we, [71:67] dest, [66:64] ld_type, [63:32] alu_result, [31:0] pc
ms_to_ws_valid  output  1  MEM presents a valid instruction to WB
ms_to_ws_bus  output  70  [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc
ms_to_ds_dest  output  5  dest when ms_valid && gr_we, else 0
ms_to_ds_result  output  32  final_result, for bypass
ms_to_ds_load_stall  output  1  MEM holds a load whose data has not yet arrived
data_sram_rdata  input  32  read data, valid when data_sram_data_ok=1
data_sram_data_ok  input  1  one-cycle pulse: read response for the load issued by EX

Behaviour:
- Reset (synchronous, active-high): ms_valid=0, bus register=0, rdata_buf=0, rdata_buf_valid=0.
  - After reset: ms_allowin=1, ms_to_ws_valid=0, ms_to_ds_dest=0, ms_to_ds_load_stall=0.
- Capture: when es_to_ms_valid && ms_allowin, register es_to_ms_bus and set rdata_buf_valid=0.
- ms_valid: on ms_allowin it is loaded with es_to_ms_valid; otherwise it holds.
- Per-instruction state, for loads only (res_from_mem=1):
  - WAIT_DATA: entered on capture. Moves to DATA_READY on data_sram_data_ok=1.
  - DATA_READY: entered when data_ok arrives. If the instruction does not leave that cycle, latch data_sram_rdata into rdata_buf and set rdata_buf_valid=1.
  - Leave: on ms_to_ws_valid && ws_allowin, rdata_buf_valid is cleared.
- data_avail = rdata_buf_valid | data_sram_data_ok.
- load_data = rdata_buf_valid ? rdata_buf : data_sram_rdata. The buffer has priority; a data_ok arriving while the buffer is already valid is ignored.
- ms_ready_go = !res_from_mem | data_avail.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- Non-loads complete in 1 cycle, with no dependence on data_ok.
- A load receiving data_ok in its first MEM cycle, with ws_allowin=1, also completes in 1 cycle.
- data_ok arriving when ms_valid=0 or res_from_mem=0 is ignored; no state changes.
- Load extraction, with a = alu_result[1:0] and ld_type[1:0] as follows:
  - 00 and 11 (word): load_data unchanged.
  - 01 (byte): select byte a. Sign-extend if ld_type[2]=0, zero-extend if 1.
  - 10 (half): select half a[1]. Sign-extend if ld_type[2]=0, zero-extend if 1. a[0] is ignored; no alignment exception is raised in this stage.
  - For word loads ld_type[2] is ignored.
- final_result = res_from_mem ? extracted load data : alu_result.
- ms_to_ds_load_stall = ms_valid & res_from_mem & !data_avail.
- ms_to_ds_dest = {5{ms_valid & gr_we}} & dest.
- Simultaneous leave and capture in the same cycle: the new instruction overwrites the bus register and rdata_buf_valid=0.
- Reset mid-load: all state cleared. A data_ok arriving after reset is ignored because ms_valid=0.

Test Plan:
- Non-load pass-through: res_from_mem=0, gr_we=1, dest=5, alu_result=0x12345678, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x12345678, ms_to_ds_dest=5, stall=0.
- Signed/unsigned byte: rdata=0x80FF7F01, data_ok=1 same cycle.
  - ld_type=001, a=3 -> final_result=0xFFFFFF80.
  - ld_type=101, a=3 -> 0x00000080.
  - ld_type=001, a=1 -> 0x0000007F.
- Halfword: rdata=0x8001ABCD.
  - ld_type=010, a=0 -> 0xFFFFABCD.
  - ld_type=110, a=2 -> 0x00008001.
  - ld_type=010, a=2 -> 0xFFFF8001.
- Delayed response: load captured, data_ok held 0 for 3 cycles -> stall=1, ms_to_ws_valid=0, ms_allowin=0 for those cycles. Fourth cycle: data_ok=1, rdata=0xDEADBEEF, ld_type=000 -> ms_to_ws_valid=1, final_result=0xDEADBEEF.
- WB backpressure: data_ok with rdata=0xCAFEF00D while ws_allowin=0 for 2 cycles, then rdata changes to 0x0 -> rdata_buf holds the value. When ws_allowin=1, WB receives 0xCAFEF00D; stall=0 throughout the wait.
- Reset mid-load and stray data_ok:
  - reset during WAIT_DATA -> ms_to_ws_valid=0, dest=0, stall=0.
  - subsequent data_ok with no load in MEM -> no output change.
  - back-to-back non-loads at ws_allowin=1 -> one retires per cycle, in order.
